// File: rtl/tile_map_renderer.sv
// tile_map_renderer: converts the game's 8x8 tile map into a 12-bit RGB pixel
// stream. The tile map is snapshotted on frame_start so a frame never tears.
// Pipeline: stage 1 computes the sprite ROM address, the ROM answers one cycle
// later, and stage 3 registers the final pixel (3 cycles end to end).
module tile_map_renderer #(
  parameter int          SCALE    = 3,
  parameter int          X0       = 128,
  parameter int          Y0       = 48,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [9:0]  h_cnt,
  input  logic [9:0]  v_cnt,
  input  logic [39:0] row1,
  input  logic [39:0] row2,
  input  logic [39:0] row3,
  input  logic [39:0] row4,
  input  logic [39:0] row5,
  input  logic [39:0] row6,
  input  logic [39:0] row7,
  input  logic [39:0] row8,
  output logic [12:0] rom_addr,
  input  logic [11:0] rom_data,
  output logic [11:0] pixel,
  output logic        pixel_valid
);

  localparam int          TILE    = 16 * SCALE;
  localparam int          AREA    = 128 * SCALE;
  localparam logic [9:0]  X0_V    = 10'(X0);
  localparam logic [9:0]  Y0_V    = 10'(Y0);
  localparam logic [10:0] X_LO    = 11'(X0);
  localparam logic [10:0] X_HI    = 11'(X0 + AREA);
  localparam logic [10:0] Y_LO    = 11'(Y0);
  localparam logic [10:0] Y_HI    = 11'(Y0 + AREA);
  localparam logic [9:0]  TILE_V  = 10'(TILE);
  localparam logic [9:0]  SCALE_V = 10'(SCALE);
  localparam logic [4:0]  DARK_IX = 5'd19;

  // Shadow tile map, entry index = {tile_row, tile_col}
  logic [4:0]  shadow_q [0:63];
  logic [4:0]  shadow_d [0:63];
  logic [39:0] rows_s   [0:7];

  logic [12:0] rom_addr_q, rom_addr_d;
  logic        s1_valid_q, s1_valid_d;
  logic        s1_show_q, s1_show_d;
  logic        s2_valid_q, s2_valid_d;
  logic        s2_show_q, s2_show_d;
  logic [11:0] pixel_q, pixel_d;
  logic        pixel_valid_q, pixel_valid_d;

  logic        inside_s;
  logic        dark_s;
  logic [9:0]  dx_s, dy_s;
  logic [2:0]  col_s, trow_s;
  logic [3:0]  sx_s, sy_s;
  logic [4:0]  idx_s;

  // Capture the whole tile map on frame_start, otherwise hold the snapshot
  always_comb begin
    rows_s[0] = row1;
    rows_s[1] = row2;
    rows_s[2] = row3;
    rows_s[3] = row4;
    rows_s[4] = row5;
    rows_s[5] = row6;
    rows_s[6] = row7;
    rows_s[7] = row8;
    for (int i = 0; i < 64; i++) begin
      shadow_d[i] = shadow_q[i];
    end
    if (frame_start) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          // column 0 sits in the most significant slice of each row word
          shadow_d[r*8 + c] = rows_s[r][39 - 5*c -: 5];
        end
      end
    end else begin
      for (int i = 0; i < 64; i++) begin
        shadow_d[i] = shadow_q[i];
      end
    end
  end

  // Stage 1: screen coordinate -> tile, texel and ROM address
  always_comb begin
    // range check is done on unsigned values before subtracting, so the
    // offsets below are only meaningful (and only used) when inside_s is set
    inside_s = pix_valid
             && ({1'b0, h_cnt} >= X_LO) && ({1'b0, h_cnt} < X_HI)
             && ({1'b0, v_cnt} >= Y_LO) && ({1'b0, v_cnt} < Y_HI);
    dx_s     = h_cnt - X0_V;
    dy_s     = v_cnt - Y0_V;
    col_s    = 3'(dx_s / TILE_V);
    trow_s   = 3'(dy_s / TILE_V);
    sx_s     = 4'((dx_s % TILE_V) / SCALE_V);
    sy_s     = 4'((dy_s % TILE_V) / SCALE_V);
    idx_s    = shadow_q[{trow_s, col_s}];
    dark_s   = (idx_s >= DARK_IX);

    s1_valid_d = pix_valid;
    s1_show_d  = inside_s && !dark_s;
    if (inside_s) begin
      rom_addr_d = {idx_s, sy_s, sx_s};
    end else begin
      rom_addr_d = rom_addr_q;
    end
  end

  // Stages 2 and 3: align flags with ROM data and select the output color
  always_comb begin
    s2_valid_d    = s1_valid_q;
    s2_show_d     = s1_show_q;
    pixel_valid_d = s2_valid_q;
    if (s2_show_q) begin
      pixel_d = rom_data;
    end else begin
      pixel_d = BG_COLOR;
    end
  end

  // Pipeline and shadow-map registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        shadow_q[i] <= 5'd31;
      end
      rom_addr_q    <= 13'd0;
      s1_valid_q    <= 1'b0;
      s1_show_q     <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_show_q     <= 1'b0;
      pixel_q       <= 12'h000;
      pixel_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < 64; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      rom_addr_q    <= rom_addr_d;
      s1_valid_q    <= s1_valid_d;
      s1_show_q     <= s1_show_d;
      s2_valid_q    <= s2_valid_d;
      s2_show_q     <= s2_show_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign pixel       = pixel_q;
  assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_tile_map_renderer.sv
// Directed testbench for tile_map_renderer with a synchronous ROM model and a
// small reference model for the streaming section.
module tb_tile_map_renderer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  h_cnt = 10'd0;
  logic [9:0]  v_cnt = 10'd0;
  logic [39:0] row1 = {8{5'd31}};
  logic [39:0] row2 = {8{5'd31}};
  logic [39:0] row3 = {8{5'd31}};
  logic [39:0] row4 = {8{5'd31}};
  logic [39:0] row5 = {8{5'd31}};
  logic [39:0] row6 = {8{5'd31}};
  logic [39:0] row7 = {8{5'd31}};
  logic [39:0] row8 = {8{5'd31}};
  logic [12:0] rom_addr;
  logic [11:0] rom_data = 12'h000;
  logic [11:0] pixel;
  logic        pixel_valid;

  logic        rom_ovr = 1'b0;
  logic [11:0] rom_ovr_val = 12'h000;

  int total = 0;
  int bad   = 0;

  logic [4:0]  sh [0:63];
  logic [12:0] exp_word [0:1023];

  tile_map_renderer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .row1(row1), .row2(row2), .row3(row3), .row4(row4),
    .row5(row5), .row6(row6), .row7(row7), .row8(row8),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pixel(pixel), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input logic [12:0] a);
    int x;
    x = int'(a);
    return 12'(x * 37 + (x >> 4) + 5);
  endfunction

  // synchronous sprite ROM model
  always @(posedge clk) begin
    rom_data <= rom_ovr ? rom_ovr_val : rom_fn(rom_addr);
  end

  // reference: {pixel_valid, pixel} for one sampled coordinate
  function automatic logic [12:0] model(input logic pv, input int h, input int v);
    int dx, dy, col, trow, sx, sy;
    logic [4:0] ix;
    if (!pv) return {1'b0, 12'h000};
    if (h < 128 || h >= 512 || v < 48 || v >= 432) return {1'b1, 12'h000};
    dx = h - 128; dy = v - 48;
    col = dx / 48; trow = dy / 48;
    sx = (dx - col * 48) / 3; sy = (dy - trow * 48) / 3;
    ix = sh[trow * 8 + col];
    if (ix >= 5'd19) return {1'b1, 12'h000};
    return {1'b1, rom_fn({ix, 4'(sy), 4'(sx)})};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input int h, input int v);
    pix_valid = pv;
    h_cnt = 10'(h);
    v_cnt = 10'(v);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    // ---------------- reset ----------------
    tick(); tick();
    check("rst_pixel", {4'h0, pixel}, 16'h0000);
    check("rst_valid", {15'd0, pixel_valid}, 16'd0);
    check("rst_addr", {3'd0, rom_addr}, 16'h0000);
    rst = 1'b0;
    drive(1'b1, 200, 100);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("rst_pv_seq", {15'd0, pixel_valid}, (i >= 3) ? 16'd1 : 16'd0);
      if (i >= 3) check("rst_dark_px", {4'h0, pixel}, 16'h0000);
    end
    drive(1'b0, 0, 0);
    tick(); tick(); tick();
    check("rst_drain", {15'd0, pixel_valid}, 16'd0);

    // ---------------- address mapping ----------------
    row1 = {8{5'd10}};
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    rom_ovr = 1'b1; rom_ovr_val = 12'hABC;
    drive(1'b1, 128, 48);  tick();
    check("addr_128_48", {3'd0, rom_addr}, 16'h0A00);
    drive(1'b1, 175, 95);  tick();
    check("addr_175_95", {3'd0, rom_addr}, 16'h0AFF);
    drive(1'b1, 511, 48);  tick();
    check("addr_right_edge", {3'd0, rom_addr}, 16'h0A0F);
    check("px_abc_lat3", {3'd0, pixel_valid, pixel}, 16'h1ABC);
    drive(1'b0, 0, 0);     tick();
    check("px_abc_2", {3'd0, pixel_valid, pixel}, 16'h1ABC);
    tick();
    check("px_abc_edge", {3'd0, pixel_valid, pixel}, 16'h1ABC);
    tick();
    check("px_bubble", {3'd0, pixel_valid, pixel}, 16'h0000);
    rom_ovr = 1'b0;

    // ---------------- column packing ----------------
    row8 = {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7};
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    drive(1'b1, 464, 384); tick();
    check("pack_idx7", {3'd0, rom_addr}, 16'h0700);
    drive(1'b1, 128, 384); tick();
    check("pack_idx0", {3'd0, rom_addr}, 16'h0000);
    drive(1'b0, 0, 0);     tick();
    check("pack_px7", {3'd0, pixel_valid, pixel}, {4'h0, 1'b1, rom_fn(13'h0700)});
    tick();
    check("pack_px0", {3'd0, pixel_valid, pixel}, {4'h0, 1'b1, rom_fn(13'h0000)});
    tick();

    // ---------------- outside / dark ----------------
    rom_ovr = 1'b1; rom_ovr_val = 12'hFFF;
    drive(1'b1, 200, 100); tick();
    check("dark_addr", {3'd0, rom_addr}, 16'h1F18);
    drive(1'b1, 127, 200); tick();
    check("left_hold_addr", {3'd0, rom_addr}, 16'h1F18);
    drive(1'b1, 512, 200); tick();
    check("right_hold_addr", {3'd0, rom_addr}, 16'h1F18);
    check("dark_px", {3'd0, pixel_valid, pixel}, 16'h1000);
    drive(1'b0, 0, 0);     tick();
    check("left_px", {3'd0, pixel_valid, pixel}, 16'h1000);
    tick();
    check("right_px", {3'd0, pixel_valid, pixel}, 16'h1000);
    tick(); tick();
    rom_ovr = 1'b0;

    // ---------------- tear-free update ----------------
    row1 = {8{5'd12}};
    drive(1'b1, 130, 50); tick();
    check("tear_no_fs", {3'd0, rom_addr}, 16'h0A00);
    frame_start = 1'b1; tick();
    frame_start = 1'b0;
    check("tear_fs_same", {3'd0, rom_addr}, 16'h0A00);
    tick();
    check("tear_after_fs", {3'd0, rom_addr}, 16'h0C00);
    check("tear_px_a", {3'd0, pixel_valid, pixel}, {4'h0, 1'b1, rom_fn(13'h0A00)});
    drive(1'b0, 0, 0); tick();
    check("tear_px_b", {3'd0, pixel_valid, pixel}, {4'h0, 1'b1, rom_fn(13'h0A00)});
    tick();
    check("tear_px_c", {3'd0, pixel_valid, pixel}, {4'h0, 1'b1, rom_fn(13'h0C00)});
    tick(); tick();

    // ---------------- streaming with random map ----------------
    for (int i = 0; i < 64; i++) sh[i] = 5'($urandom_range(0, 31));
    row1 = {sh[0],  sh[1],  sh[2],  sh[3],  sh[4],  sh[5],  sh[6],  sh[7]};
    row2 = {sh[8],  sh[9],  sh[10], sh[11], sh[12], sh[13], sh[14], sh[15]};
    row3 = {sh[16], sh[17], sh[18], sh[19], sh[20], sh[21], sh[22], sh[23]};
    row4 = {sh[24], sh[25], sh[26], sh[27], sh[28], sh[29], sh[30], sh[31]};
    row5 = {sh[32], sh[33], sh[34], sh[35], sh[36], sh[37], sh[38], sh[39]};
    row6 = {sh[40], sh[41], sh[42], sh[43], sh[44], sh[45], sh[46], sh[47]};
    row7 = {sh[48], sh[49], sh[50], sh[51], sh[52], sh[53], sh[54], sh[55]};
    row8 = {sh[56], sh[57], sh[58], sh[59], sh[60], sh[61], sh[62], sh[63]};
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int t = 0; t < 703; t++) begin
      logic pv;
      int h, v;
      if (t < 640) begin
        pv = 1'b1; h = t; v = 60;
      end else if (t < 700) begin
        pv = ((t % 3) != 0); h = 100 + (t - 640) * 5; v = 200;
      end else begin
        pv = 1'b0; h = 0; v = 0;
      end
      exp_word[t] = model(pv, h, v);
      drive(pv, h, v);
      tick();
      if (t >= 2) begin
        check("stream", {3'd0, pixel_valid, pixel}, {3'd0, exp_word[t - 2]});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
